// File: rtl/alu_seq_muldiv.sv
// Multi-cycle ALU: 16 registered single-cycle operations plus iterative unsigned
// shift-add multiply and restoring divide, with valid/ready on both sides.
module alu_seq_muldiv #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   aluop,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic [N-1:0] hi,
    output logic         carry_out,
    output logic         zero,
    output logic         neg,
    output logic         div_zero
);

    localparam int CW = $clog2(N + 1);
    localparam logic [4:0] OP_MULU = 5'h10;
    localparam logic [4:0] OP_DIVU = 5'h11;

    // Handshake: a request is taken when in_valid && in_ready; a result is
    // taken when out_valid && out_ready. Both may happen on the same edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [4:0]     op_q;
    logic [N-1:0]   a_q, b_q;
    logic           cin_q;
    logic [N-1:0]   acc_q;
    logic [N-1:0]   lo_q;
    logic [N-1:0]   y_q, hi_q;
    logic           carry_q, zero_q, neg_q, dz_q, out_valid_q;

    logic           accept;
    logic           iter_en;
    logic           finish;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (aluop == OP_MULU)      state_d = S_MUL;
                    else if (aluop == OP_DIVU) state_d = S_DIV;
                    else                       state_d = S_DONE;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        iter_en  = (state_q == S_MUL) || (state_q == S_DIV);
        finish   = (state_q == S_DONE);
    end

    // ---------------- single-cycle operations ----------------
    logic [N:0] r;
    always_comb begin
        r = '0;
        unique case (op_q[3:0])
            4'h0: r = '0;
            4'h1: r = {1'b0, a_q};
            4'h2: r = {1'b0, a_q} + {{N{1'b0}}, 1'b1};
            4'h3: r = {1'b0, a_q} - {{N{1'b0}}, 1'b1};
            4'h4: r = {a_q, 1'b0};
            4'h5: r = {a_q[0], 1'b0, a_q[N-1:1]};
            4'h6: r = {a_q, cin_q};
            4'h7: r = {a_q[0], cin_q, a_q[N-1:1]};
            4'h8: r = {1'b0, a_q | b_q};
            4'h9: r = {1'b0, a_q & b_q};
            4'hA: r = {1'b0, a_q ^ b_q};
            4'hB: r = {1'b0, b_q};
            4'hC: r = {1'b0, a_q} + {1'b0, b_q};
            4'hD: r = {1'b0, a_q} - {1'b0, b_q};
            4'hE: r = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};
            4'hF: r = {1'b0, a_q} - {1'b0, b_q} - {{N{1'b0}}, cin_q};
            default: r = '0;
        endcase
    end

    // ---------------- one multiply / divide iteration ----------------
    // Multiply: acc holds the running high half, lo shifts the multiplier out
    // and the product low half in. Divide: acc is the partial remainder, lo
    // shifts the dividend out and the quotient in.
    logic [N:0]   mul_sum;
    logic [N:0]   div_shift;
    logic         div_borrow;
    logic [N-1:0] div_diff;
    logic [N-1:0] acc_d, lo_d;

    always_comb begin
        mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : {(N+1){1'b0}});
        div_shift  = {acc_q, lo_q[N-1]};
        div_borrow = div_shift < {1'b0, b_q};
        div_diff   = div_shift[N-1:0] - b_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        if (state_q == S_MUL) begin
            acc_d = mul_sum[N:1];
            lo_d  = {mul_sum[0], lo_q[N-1:1]};
        end else if (state_q == S_DIV) begin
            acc_d = div_borrow ? div_shift[N-1:0] : div_diff;
            lo_d  = {lo_q[N-2:0], ~div_borrow};
        end
    end

    // ---------------- final result selection ----------------
    logic [N-1:0] y_fin, hi_fin;
    logic         c_fin, dz_fin;

    always_comb begin
        y_fin  = '0;
        hi_fin = '0;
        c_fin  = 1'b0;
        dz_fin = 1'b0;
        if (op_q == OP_MULU) begin
            y_fin  = lo_q;
            hi_fin = acc_q;
            c_fin  = |acc_q;
        end else if (op_q == OP_DIVU) begin
            // B == 0 falls out of the iteration as all-ones quotient, remainder A
            y_fin  = lo_q;
            hi_fin = acc_q;
            dz_fin = (b_q == '0);
        end else if (!op_q[4]) begin
            y_fin  = r[N-1:0];
            c_fin  = r[N];
        end
    end

    // ---------------- operand capture and iteration registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            lo_q  <= '0;
        end else if (accept) begin
            op_q  <= aluop;
            a_q   <= a;
            b_q   <= b;
            cin_q <= carry_in;
            cnt_q <= CW'(N - 1);
            acc_q <= '0;
            lo_q  <= (aluop == OP_DIVU) ? a : b;
        end else if (iter_en) begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
    end

    // ---------------- result registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q         <= '0;
            hi_q        <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (finish) begin
            y_q         <= y_fin;
            hi_q        <= hi_fin;
            carry_q     <= c_fin;
            zero_q      <= (y_fin == '0);
            neg_q       <= y_fin[N-1];
            dz_q        <= dz_fin;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign y         = y_q;
    assign hi        = hi_q;
    assign carry_out = carry_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign div_zero  = dz_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv at N=16: single-cycle ops, multiply/divide,
// result hold and back-to-back accept, and reset during an iteration.
module tb_alu_seq_muldiv;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  aluop;
    logic [15:0] a, b;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y, hi;
    logic        carry_out, zero, neg, div_zero;

    logic [35:0] res;
    assign res = {y, hi, carry_out, zero, neg, div_zero};

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_muldiv #(.N(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .hi        (hi),
        .carry_out (carry_out),
        .zero      (zero),
        .neg       (neg),
        .div_zero  (div_zero)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [4:0] op, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        aluop    = op;
        a        = av;
        b        = bv;
        carry_in = cv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        a         = 16'hA5A5;
        b         = 16'h5A5A;
        carry_in  = ~cv;
        out_ready = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) busy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        aluop = '0; a = '0; b = '0; carry_in = 1'b0;
        #12;
        n_cmp++;
        if ({out_valid, res} !== 37'h0) begin
            n_err++;
            $display("FAIL reset_outputs got %h required %h", {out_valid, res}, 37'h0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        logic [4:0]  ops [7] = '{5'h0C, 5'h0F, 5'h05, 5'h07, 5'h15, 5'h03, 5'h0E};
        logic [15:0] avs [7] = '{16'hFFFF, 16'h0000, 16'h0003, 16'h0002, 16'hFFFF, 16'h0000, 16'h7FFF};
        logic [15:0] bvs [7] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        logic        cvs [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [35:0] exps[7] = '{{16'h0000, 16'h0000, 4'b1100},
                                 {16'hFFFE, 16'h0000, 4'b1010},
                                 {16'h0001, 16'h0000, 4'b1000},
                                 {16'h8001, 16'h0000, 4'b0010},
                                 {16'h0000, 16'h0000, 4'b0100},
                                 {16'hFFFF, 16'h0000, 4'b1010},
                                 {16'h8000, 16'h0000, 4'b0010}};
        int lat, busy;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], avs[i], bvs[i], cvs[i]);
            wait_result(lat, busy);
            n_cmp++;
            if (lat !== 1) begin
                n_err++;
                $display("FAIL single_latency op=%h got %0d required 1", ops[i], lat);
            end
            n_cmp++;
            if (res !== exps[i]) begin
                n_err++;
                $display("FAIL single_result op=%h got %h required %h", ops[i], res, exps[i]);
            end
            consume();
        end
    endtask

    task automatic test_muldiv();
        logic [4:0]  ops [3] = '{5'h10, 5'h10, 5'h11};
        logic [15:0] avs [3] = '{16'h1234, 16'hFFFF, 16'h0064};
        logic [15:0] bvs [3] = '{16'h0100, 16'hFFFF, 16'h0007};
        logic [35:0] exps[3] = '{{16'h3400, 16'h0012, 4'b1000},
                                 {16'h0001, 16'hFFFE, 4'b1000},
                                 {16'h000E, 16'h0002, 4'b0000}};
        int lat, busy;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], avs[i], bvs[i], 1'b0);
            wait_result(lat, busy);
            n_cmp++;
            if (lat !== 17) begin
                n_err++;
                $display("FAIL muldiv_latency op=%h got %0d required 17", ops[i], lat);
            end
            n_cmp++;
            if (busy !== 0) begin
                n_err++;
                $display("FAIL muldiv_in_ready_busy op=%h got %0d high cycles required 0", ops[i], busy);
            end
            n_cmp++;
            if (res !== exps[i]) begin
                n_err++;
                $display("FAIL muldiv_result op=%h got %h required %h", ops[i], res, exps[i]);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] exp_dz = {16'hFFFF, 16'h0005, 4'b0011};
        logic [35:0] exp_or = {16'h00FF, 16'h0000, 4'b0000};
        int lat, busy, bad;
        issue(5'h11, 16'h0005, 16'h0000, 1'b0);
        wait_result(lat, busy);
        n_cmp++;
        if (lat !== 17 || res !== exp_dz) begin
            n_err++;
            $display("FAIL divzero_result got lat=%0d %h required lat=17 %h", lat, res, exp_dz);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (res !== exp_dz || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL hold_stable got %0d unstable cycles required 0", bad);
        end
        out_ready = 1'b1;
        #0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_in_ready got %b required 1", in_ready);
        end
        issue(5'h08, 16'h00F0, 16'h000F, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_old_dropped got out_valid=%b required 0", out_valid);
        end
        wait_result(lat, busy);
        n_cmp++;
        if (lat !== 1 || res !== exp_or) begin
            n_err++;
            $display("FAIL b2b_result got lat=%0d %h required lat=1 %h", lat, res, exp_or);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [35:0] exp_ld = {16'h1234, 16'h0000, 4'b0000};
        int lat, busy;
        issue(5'h10, 16'h1234, 16'h0100, 1'b0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, res} !== 37'h0) begin
            n_err++;
            $display("FAIL reset_mid_outputs got %h required %h", {out_valid, res}, 37'h0);
        end
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_release got in_ready=%b out_valid=%b required 1 0",
                     in_ready, out_valid);
        end
        issue(5'h0B, 16'h0000, 16'h1234, 1'b0);
        wait_result(lat, busy);
        n_cmp++;
        if (lat !== 1 || res !== exp_ld) begin
            n_err++;
            $display("FAIL load_b_after_reset got lat=%0d %h required lat=1 %h", lat, res, exp_ld);
        end
        consume();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_muldiv();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
